alu_sequencer: RTL and testbench



---
 rtl/alu_seq_pkg.sv | 90 +++++++++
 rtl/alu_sequencer_regfile.sv | 37 +++
 rtl/alu_sequencer.sv | 155 +++++++++++++++
 tb/tb_alu_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: state encoding, CR16 op/ext codes,
// PSR bit positions and the instruction classification used by decode.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DECODE    = 2'd1,
        ST_EXECUTE   = 2'd2,
        ST_WRITEBACK = 2'd3
    } state_t;

    // Major opcodes (instr[15:12]); immediate forms reuse the register ext codes
    localparam logic [3:0] OP_REG   = 4'h0;
    localparam logic [3:0] OP_ANDI  = 4'h1;
    localparam logic [3:0] OP_ORI   = 4'h2;
    localparam logic [3:0] OP_XORI  = 4'h3;
    localparam logic [3:0] OP_ADDI  = 4'h5;
    localparam logic [3:0] OP_SHIFT = 4'h8;
    localparam logic [3:0] OP_SUBI  = 4'h9;
    localparam logic [3:0] OP_CMPI  = 4'hB;
    localparam logic [3:0] OP_MOVI  = 4'hD;
    localparam logic [3:0] OP_IMMF  = 4'hF;

    localparam logic [3:0] EXT_AND    = 4'h1;
    localparam logic [3:0] EXT_OR     = 4'h2;
    localparam logic [3:0] EXT_XOR    = 4'h3;
    localparam logic [3:0] EXT_ADD    = 4'h5;
    localparam logic [3:0] EXT_ADDU   = 4'h6;
    localparam logic [3:0] EXT_SUB    = 4'h9;
    localparam logic [3:0] EXT_CMP    = 4'hB;
    localparam logic [3:0] EXT_MOV    = 4'hD;
    localparam logic [3:0] EXT_LSH    = 4'h4;
    localparam logic [3:0] EXT_LSHI_L = 4'h0;
    localparam logic [3:0] EXT_LSHI_R = 4'h1;

    localparam int PSR_C = 4;
    localparam int PSR_L = 3;
    localparam int PSR_F = 2;
    localparam int PSR_Z = 1;
    localparam int PSR_N = 0;

    typedef enum logic [1:0] {
        B_REG   = 2'd0,
        B_SHAMT = 2'd1,
        B_IMM8  = 2'd2
    } bsel_t;

    typedef struct packed {
        logic  legal;
        logic  writes_rd;
        logic  sets_psr;
        bsel_t bsel;
    } op_class_t;

    function automatic op_class_t classify(input logic [3:0] op, input logic [3:0] ext);
        op_class_t c;
        c = '0;
        case (op)
            OP_REG: begin
                if (ext inside {EXT_AND, EXT_OR, EXT_XOR, EXT_ADD, EXT_ADDU,
                                EXT_SUB, EXT_CMP, EXT_MOV}) begin
                    c.legal     = 1'b1;
                    c.writes_rd = (ext != EXT_CMP);
                    c.sets_psr  = ext inside {EXT_AND, EXT_ADD, EXT_SUB, EXT_CMP};
                    c.bsel      = B_REG;
                end
            end
            OP_SHIFT: begin
                if (ext == EXT_LSH) begin
                    c.legal     = 1'b1;
                    c.writes_rd = 1'b1;
                    c.bsel      = B_REG;
                end else if (ext inside {EXT_LSHI_L, EXT_LSHI_R}) begin
                    c.legal     = 1'b1;
                    c.writes_rd = 1'b1;
                    c.bsel      = B_SHAMT;
                end
            end
            OP_ANDI, OP_ORI, OP_XORI, OP_ADDI, OP_SUBI, OP_CMPI, OP_MOVI, OP_IMMF: begin
                c.legal     = 1'b1;
                c.writes_rd = (op != OP_CMPI);
                c.sets_psr  = op inside {OP_ANDI, OP_ADDI, OP_SUBI, OP_CMPI};
                c.bsel      = B_IMM8;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_sequencer_regfile.sv
// General register file: NREGS x 16, two combinational read ports, one
// synchronous write port and a combinational debug read port.
module regfile #(
    parameter int          NREGS     = 16,
    parameter logic [15:0] RESET_VAL = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [3:0]  i_raddr_a,
    input  logic [3:0]  i_raddr_b,
    output logic [15:0] o_rdata_a,
    output logic [15:0] o_rdata_b,
    input  logic        i_we,
    input  logic [3:0]  i_waddr,
    input  logic [15:0] i_wdata,
    input  logic [3:0]  i_dbg_addr,
    output logic [15:0] o_dbg_data
);

    logic [15:0] r_mem [NREGS];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= RESET_VAL;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Reads see the pre-write value during a write cycle
    assign o_rdata_a  = r_mem[i_raddr_a];
    assign o_rdata_b  = r_mem[i_raddr_b];
    assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Four-state controller that runs one CR16-style instruction at a time on an
// external combinational ALU, owning the register file and the PSR.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int          NREGS     = 16,
    parameter logic [15:0] RESET_VAL = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic        done,
    output logic        illegal_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [7:0]  alu_opcode,
    input  logic [15:0] alu_c,
    input  logic [4:0]  alu_flags,
    output logic [4:0]  psr,
    input  logic [3:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_instr;
    logic [15:0] r_result;
    logic [4:0]  r_flags;
    logic [4:0]  r_psr;
    logic [15:0] r_alu_a;
    logic [15:0] r_alu_b;
    logic [7:0]  r_alu_op;

    logic [3:0]  w_op;
    logic [3:0]  w_rdest;
    logic [3:0]  w_ext;
    logic [3:0]  w_rsrc;
    logic [7:0]  w_imm;
    op_class_t   w_cls;
    logic [15:0] w_rd_a;
    logic [15:0] w_rd_b;
    logic [15:0] w_b_sel;
    logic        w_we;
    logic        w_ready;
    logic        w_done;
    logic        w_illegal;

    assign w_op    = r_instr[15:12];
    assign w_rdest = r_instr[11:8];
    assign w_ext   = r_instr[7:4];
    assign w_rsrc  = r_instr[3:0];
    assign w_imm   = r_instr[7:0];
    assign w_cls   = classify(w_op, w_ext);

    regfile #(
        .NREGS     (NREGS),
        .RESET_VAL (RESET_VAL)
    ) u_regfile (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_raddr_a  (w_rdest),
        .i_raddr_b  (w_rsrc),
        .o_rdata_a  (w_rd_a),
        .o_rdata_b  (w_rd_b),
        .i_we       (w_we),
        .i_waddr    (w_rdest),
        .i_wdata    (r_result),
        .i_dbg_addr (dbg_addr),
        .o_dbg_data (dbg_data)
    );

    // Immediates go out zero-padded; the ALU owns any sign extension
    always_comb begin
        case (w_cls.bsel)
            B_SHAMT: w_b_sel = {12'h000, w_rsrc};
            B_IMM8:  w_b_sel = {8'h00, w_imm};
            default: w_b_sel = w_rd_b;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_done      = 1'b0;
        w_illegal   = 1'b0;
        w_we        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (instr_valid) begin
                    w_state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (w_cls.legal) begin
                    w_state_nxt = ST_EXECUTE;
                end else begin
                    w_illegal   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EXECUTE: begin
                w_state_nxt = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                w_done      = 1'b1;
                w_we        = w_cls.writes_rd;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_psr    <= '0;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_DECODE && w_cls.legal) begin
                r_alu_a  <= w_rd_a;
                r_alu_b  <= w_b_sel;
                r_alu_op <= {w_op, w_ext};
            end
            if (r_state == ST_WRITEBACK && w_cls.sets_psr) begin
                r_psr <= r_flags;
            end
        end
    end

    // Instruction and result latches carry data only; the state gates their use
    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE && instr_valid) begin
            r_instr <= instr;
        end
        if (r_state == ST_EXECUTE) begin
            r_result <= alu_c;
            r_flags  <= alu_flags;
        end
    end

    assign instr_ready = w_ready;
    assign done        = w_done;
    assign illegal_op  = w_illegal;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_opcode  = r_alu_op;
    assign psr         = r_psr;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: a behavioural ALU drives alu_c/alu_flags,
// an instruction-level reference model predicts each completion.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = '0;
    logic        instr_ready;
    logic        done;
    logic        illegal_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [7:0]  alu_opcode;
    logic [15:0] alu_c;
    logic [4:0]  alu_flags;
    logic [4:0]  psr;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;
    logic [20:0] alu_out;

    logic [3:0]  probe_addr = '0;
    logic [3:0]  mon_addr = '0;
    logic        mon_sel = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        bit          ill;
        int          acc;
        logic [3:0]  rd;
        logic [15:0] val;
        logic [4:0]  psr;
        logic [15:0] ins;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_reg [16];
    logic [4:0]  m_psr;

    alu_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .done        (done),
        .illegal_op  (illegal_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_opcode  (alu_opcode),
        .alu_c       (alu_c),
        .alu_flags   (alu_flags),
        .psr         (psr),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign dbg_addr = mon_sel ? mon_addr : probe_addr;

    // Behavioural ALU: logical immediates zero-extend, arithmetic ones sign-extend
    function automatic logic [20:0] alu_fn(input logic [7:0] opc, input logic [15:0] a,
                                           input logic [15:0] b);
        logic [3:0]  op;
        logic [3:0]  fn;
        logic [15:0] bb;
        logic [15:0] c;
        logic [16:0] s;
        logic [4:0]  f;
        op = opc[7:4];
        fn = (op == 4'h0) ? opc[3:0] : op;
        c  = '0;
        f  = '0;
        s  = '0;
        bb = b;
        if (op != 4'h0 && op != 4'h8 && !(op inside {4'h1, 4'h2, 4'h3}))
            bb = {{8{b[7]}}, b[7:0]};
        if (op == 4'h8) begin
            c = (opc[3:0] == 4'h1) ? (a >> b[3:0]) : (a << b[3:0]);
        end else begin
            case (fn)
                4'h1: c = a & bb;
                4'h2: c = a | bb;
                4'h3: c = a ^ bb;
                4'h5, 4'h6: begin
                    s = {1'b0, a} + {1'b0, bb};
                    c = s[15:0];
                    f[PSR_C] = s[16];
                    f[PSR_F] = (a[15] == bb[15]) && (c[15] != a[15]);
                end
                4'h9: begin
                    s = {1'b0, a} - {1'b0, bb};
                    c = s[15:0];
                    f[PSR_C] = s[16];
                    f[PSR_F] = (a[15] != bb[15]) && (c[15] != a[15]);
                end
                4'hB: begin
                    c = a - bb;
                    f[PSR_Z] = (a == bb);
                    f[PSR_L] = (bb > a);
                    f[PSR_N] = ($signed(bb) > $signed(a));
                end
                4'hD: c = bb;
                default: c = a ^ {bb[7:0], bb[15:8]};
            endcase
            if (fn inside {4'h1, 4'h2, 4'h3}) begin
                f[PSR_Z] = (c == 16'h0000);
                f[PSR_N] = c[15];
            end
        end
        return {f, c};
    endfunction

    assign alu_out   = alu_fn(alu_opcode, alu_a, alu_b);
    assign alu_c     = alu_out[15:0];
    assign alu_flags = alu_out[20:16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = 16'h0000;
        m_psr = 5'b00000;
    endtask

    // Instruction-level semantics: classify by mnemonic, fetch operands, apply
    task automatic model_step(input logic [15:0] w, output exp_t e);
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [3:0]  ext;
        logic [3:0]  rs;
        logic [15:0] b;
        logic [20:0] r;
        bit is_reg, is_lsh, is_lshi, is_imm, is_cmp, sets;
        op = w[15:12]; rd = w[11:8]; ext = w[7:4]; rs = w[3:0];
        is_reg  = (op == 4'h0) && (ext inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h9, 4'hB, 4'hD});
        is_lsh  = (op == 4'h8) && (ext == 4'h4);
        is_lshi = (op == 4'h8) && (ext inside {4'h0, 4'h1});
        is_imm  = op inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD, 4'hF};
        is_cmp  = (is_reg && ext == 4'hB) || (op == 4'hB);
        sets    = (is_reg && (ext inside {4'h1, 4'h5, 4'h9, 4'hB})) ||
                  (op inside {4'h1, 4'h5, 4'h9, 4'hB});
        e.ill = !(is_reg || is_lsh || is_lshi || is_imm);
        if (!e.ill) begin
            if (is_reg || is_lsh) b = m_reg[rs];
            else if (is_lshi)     b = {12'h000, rs};
            else                  b = {8'h00, w[7:0]};
            r = alu_fn({op, ext}, m_reg[rd], b);
            if (!is_cmp) m_reg[rd] = r[15:0];
            if (sets)    m_psr = r[20:16];
        end
        e.acc = 0;
        e.rd  = rd;
        e.val = m_reg[rd];
        e.psr = m_psr;
        e.ins = w;
    endtask

    task automatic issue(input logic [15:0] w, input bit hold, output int acc);
        exp_t e;
        int   n;
        @(negedge clk);
        instr       = w;
        instr_valid = 1'b1;
        n           = 0;
        acc         = -1;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            chk($sformatf("accept_timeout_%h", w), 32'(instr_ready), 32'd1);
            instr_valid = 1'b0;
            return;
        end
        model_step(w, e);
        e.acc = cyc + 1;
        acc   = e.acc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("completion_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_reg(input logic [3:0] a, input logic [15:0] v, input string nm);
        probe_addr = a;
        #1;
        chk(nm, 32'(dbg_data), 32'(v));
    endtask

    // Monitor: pops one expectation per done/illegal_op pulse
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done || illegal_op) begin
                if (sb.size() == 0) begin
                    chk("unexpected_completion", {30'd0, done, illegal_op}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("illegal_flag_%h", e.ins), 32'(illegal_op), 32'(e.ill));
                    chk($sformatf("done_flag_%h", e.ins), 32'(done), 32'(!e.ill));
                    chk($sformatf("latency_%h", e.ins), 32'(cyc - e.acc), e.ill ? 32'd0 : 32'd2);
                    @(posedge clk);
                    #1;
                    mon_addr = e.rd;
                    mon_sel  = 1'b1;
                    #1;
                    chk($sformatf("rd_value_%h", e.ins), 32'(dbg_data), 32'(e.val));
                    chk($sformatf("psr_%h", e.ins), 32'(psr), 32'(e.psr));
                    mon_sel = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog_expired actual=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2, acc;
        logic [15:0] w;
        bit hold;
        model_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("reset_ready", 32'(instr_ready), 32'd1);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_illegal", 32'(illegal_op), 32'd0);
        chk("reset_psr", 32'(psr), 32'd0);
        chk("reset_alu", {alu_opcode, alu_a ^ alu_b}, 32'd0);
        chk("reset_alu_a", 32'(alu_a), 32'd0);
        for (int i = 0; i < 16; i++) chk_reg(4'(i), 16'h0000, $sformatf("reset_r%0d", i));

        issue(16'hD12A, 1'b0, acc);
        wait_idle();
        chk_reg(4'd1, 16'h002A, "movi_r1");
        chk("movi_psr", 32'(psr), 32'd0);

        issue(16'hD17F, 1'b0, acc);
        issue(16'h8108, 1'b0, acc);
        issue(16'h21FF, 1'b0, acc);
        issue(16'hD201, 1'b0, acc);
        wait_idle();
        chk_reg(4'd1, 16'h7FFF, "add_setup_r1");
        issue(16'h0152, 1'b0, acc);
        wait_idle();
        chk_reg(4'd1, 16'h8000, "add_r1");
        chk("add_psr_f", 32'(psr[PSR_F]), 32'd1);
        chk("add_psr_c", 32'(psr[PSR_C]), 32'd0);

        issue(16'hD305, 1'b0, acc);
        issue(16'hD407, 1'b0, acc);
        issue(16'h03B4, 1'b0, acc);
        wait_idle();
        chk_reg(4'd3, 16'h0005, "cmp_r3_kept");
        chk("cmp_psr_l", 32'(psr[PSR_L]), 32'd1);
        chk("cmp_psr_n", 32'(psr[PSR_N]), 32'd1);
        chk("cmp_psr_z", 32'(psr[PSR_Z]), 32'd0);

        issue(16'h4000, 1'b0, acc);
        @(negedge clk);
        chk("illegal_busy", 32'(instr_ready), 32'd0);
        @(negedge clk);
        chk("illegal_ready_back", 32'(instr_ready), 32'd1);
        wait_idle();
        chk("illegal_psr_kept", 32'(psr), 32'b01001);
        chk_reg(4'd0, 16'h0000, "illegal_r0_kept");

        issue(16'hD501, 1'b0, acc);
        issue(16'h8503, 1'b0, acc);
        wait_idle();
        chk_reg(4'd5, 16'h0008, "lshi_r5");
        chk("lshi_psr_kept", 32'(psr), 32'b01001);
        issue(16'h25F0, 1'b0, acc);
        wait_idle();
        chk_reg(4'd5, 16'h00F8, "ori_r5");

        issue(16'hD611, 1'b1, a0);
        issue(16'h5601, 1'b1, a1);
        issue(16'h0166, 1'b0, a2);
        chk("b2b_gap1", 32'(a1 - a0), 32'd4);
        chk("b2b_gap2", 32'(a2 - a1), 32'd4);
        wait_idle();
        chk_reg(4'd6, 16'h0012, "b2b_r6");

        issue(16'h5611, 1'b0, acc);
        @(posedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_exec_ready", 32'(instr_ready), 32'd1);
        chk("rst_exec_psr", 32'(psr), 32'd0);
        chk("rst_exec_done", 32'(done), 32'd0);
        @(negedge clk);
        chk_reg(4'd6, 16'h0000, "rst_exec_r6");
        chk_reg(4'd1, 16'h0000, "rst_exec_r1");

        for (int k = 0; k < 150; k++) begin
            w    = 16'($urandom());
            hold = (k == 149) ? 1'b0 : 1'($urandom_range(0, 1));
            issue(w, hold, acc);
        end
        instr_valid = 1'b0;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
